// File: rtl/cpu_wrapper_v3.sv
// Small 8-bit accumulator-less CPU: 4 registers (R3 = SP), unified 256x8 memory,
// one-cycle one-byte instructions, two-cycle LDM/LDD/STD, single-level interrupt.

module cpu_pc (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rst_vec,
  input  logic [7:0] pc_next,
  output logic [7:0] pc_current
);
  always_ff @(posedge clk) begin
    if (!rstn) pc_current <= rst_vec;
    else       pc_current <= pc_next;
  end
endmodule

module cpu_regfile (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [1:0]      sel,
  input  logic [7:0]      wd,
  input  logic            sp_we,
  input  logic [7:0]      sp_wd,
  output logic [3:0][7:0] regs_o
);
  logic [3:0][7:0] regs;

  // A general write to R3 (e.g. POP SP) wins over the stack-pointer update.
  always_ff @(posedge clk) begin
    if (!rstn) regs <= {8'hFF, 8'h00, 8'h00, 8'h00};
    else begin
      for (int i = 0; i < 4; i++) begin
        if (we && sel == 2'(i)) regs[i] <= wd;
        else if (i == 3 && sp_we) regs[i] <= sp_wd;
      end
    end
  end

  assign regs_o = regs;
endmodule

module cpu_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [7:0] raddr_b,
  output logic [7:0] rdata_b
);
  logic [7:0] mem [0:255];

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

module cpu_wrapper_v3 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_Port,
  input  logic       int_sig,
  output logic [7:0] O_Port
);
  typedef enum logic {S_EXEC, S_OP2} state_e;
  typedef struct packed { logic z; logic n; logic c; logic v; } flags_t;

  state_e          state_q, state_d;
  logic [7:0]      ir_q, ir_d, oport_q, oport_d;
  flags_t          flags_q, flags_d, fsave_q, fsave_d, alu_f;
  logic            imask_q, imask_d;

  logic [7:0]      pc, pc_d, fetch, dmem, daddr;
  logic [3:0][7:0] rf;
  logic            rf_we, sp_we, mem_we;
  logic [1:0]      rf_sel;
  logic [7:0]      rf_wd, sp_wd, mem_wa, mem_wd;

  logic [7:0]      instr, rav, rbv, sp, alu_res;
  logic [3:0]      op;
  logic [1:0]      ra, rb;
  logic [8:0]      sum;
  logic            int_take, jmp_tkn;

  cpu_pc PC (
    .clk(clk), .rstn(rstn), .rst_vec(dmem), .pc_next(pc_d), .pc_current(pc)
  );

  cpu_regfile regfile_inst (
    .clk(clk), .rstn(rstn), .we(rf_we), .sel(rf_sel), .wd(rf_wd),
    .sp_we(sp_we), .sp_wd(sp_wd), .regs_o(rf)
  );

  cpu_mem mem_inst (
    .clk(clk), .we(mem_we), .waddr(mem_wa), .wdata(mem_wd),
    .raddr_a(pc), .rdata_a(fetch), .raddr_b(daddr), .rdata_b(dmem)
  );

  // In the second cycle of a two-byte op, the latched opcode is decoded and
  // the byte now under PC is the immediate/address.
  assign instr    = (state_q == S_OP2) ? ir_q : fetch;
  assign op       = instr[7:4];
  assign ra       = instr[3:2];
  assign rb       = instr[1:0];
  assign rav      = rf[ra];
  assign rbv      = rf[rb];
  assign sp       = rf[3];
  assign int_take = (state_q == S_EXEC) && int_sig && !imask_q;

  always_comb begin
    if (!rstn)                  daddr = 8'h00;
    else if (int_take)          daddr = 8'h01;
    else if (state_q == S_OP2)  daddr = fetch;
    else if (op == 4'hD)        daddr = rav;
    else                        daddr = sp + 8'd1;
  end

  always_comb begin
    alu_res = rbv;
    alu_f   = flags_q;
    sum     = '0;
    case (op)
      4'h2: begin
        sum = {1'b0, rav} + {1'b0, rbv}; alu_res = sum[7:0];
        alu_f.c = sum[8]; alu_f.v = (rav[7] == rbv[7]) && (alu_res[7] != rav[7]);
      end
      4'h3: begin
        sum = {1'b0, rav} - {1'b0, rbv}; alu_res = sum[7:0];
        alu_f.c = sum[8]; alu_f.v = (rav[7] != rbv[7]) && (alu_res[7] != rav[7]);
      end
      4'h4: begin alu_res = rav & rbv; alu_f.c = 1'b0; alu_f.v = 1'b0; end
      4'h5: begin alu_res = rav | rbv; alu_f.c = 1'b0; alu_f.v = 1'b0; end
      4'h6: begin
        case (ra)
          2'd0:    begin alu_res = {rbv[6:0], flags_q.c}; alu_f.c = rbv[7]; end
          2'd1:    begin alu_res = {flags_q.c, rbv[7:1]}; alu_f.c = rbv[0]; end
          2'd2:    alu_f.c = 1'b1;
          default: alu_f.c = 1'b0;
        endcase
      end
      4'h8: begin
        case (ra)
          2'd0: begin alu_res = ~rbv; alu_f.c = 1'b0; alu_f.v = 1'b0; end
          2'd1: begin
            sum = 9'd0 - {1'b0, rbv}; alu_res = sum[7:0];
            alu_f.c = sum[8]; alu_f.v = (rbv == 8'h80);
          end
          2'd2: begin
            sum = {1'b0, rbv} + 9'd1; alu_res = sum[7:0];
            alu_f.c = sum[8]; alu_f.v = (rbv == 8'h7F);
          end
          default: begin
            sum = {1'b0, rbv} - 9'd1; alu_res = sum[7:0];
            alu_f.c = sum[8]; alu_f.v = (rbv == 8'h80);
          end
        endcase
      end
      default: ;
    endcase
    if (!(op == 4'h6 && ra[1])) begin
      alu_f.z = (alu_res == 8'h00);
      alu_f.n = alu_res[7];
    end
  end

  always_comb begin
    case (ra)
      2'd0:    jmp_tkn = flags_q.z;
      2'd1:    jmp_tkn = flags_q.n;
      2'd2:    jmp_tkn = flags_q.c;
      default: jmp_tkn = flags_q.v;
    endcase
  end

  always_comb begin
    pc_d    = pc + 8'd1;
    state_d = S_EXEC;
    ir_d    = ir_q;
    flags_d = flags_q;
    fsave_d = fsave_q;
    imask_d = imask_q;
    oport_d = oport_q;
    rf_we   = 1'b0;
    rf_sel  = rb;
    rf_wd   = alu_res;
    sp_we   = 1'b0;
    sp_wd   = sp;
    mem_we  = 1'b0;
    mem_wa  = sp;
    mem_wd  = rbv;
    if (int_take) begin
      mem_we = 1'b1; mem_wd = pc; sp_we = 1'b1; sp_wd = sp - 8'd1;
      fsave_d = flags_q; imask_d = 1'b1; pc_d = dmem;
    end else if (state_q == S_OP2) begin
      case (ra)
        2'd0:    begin rf_we = 1'b1; rf_wd = fetch; end
        2'd1:    begin rf_we = 1'b1; rf_wd = dmem; end
        default: begin mem_we = 1'b1; mem_wa = fetch; end
      endcase
    end else begin
      case (op)
        4'h1: begin rf_we = 1'b1; rf_sel = ra; rf_wd = rbv; end
        4'h2, 4'h3, 4'h4, 4'h5: begin rf_we = 1'b1; rf_sel = ra; flags_d = alu_f; end
        4'h6: begin rf_we = !ra[1]; flags_d = alu_f; end
        4'h7: begin
          case (ra)
            2'd0: begin mem_we = 1'b1; sp_we = 1'b1; sp_wd = sp - 8'd1; end
            2'd1: begin sp_we = 1'b1; sp_wd = sp + 8'd1; rf_we = 1'b1; rf_wd = dmem; end
            2'd2: oport_d = rbv;
            default: begin rf_we = 1'b1; rf_wd = I_Port; end
          endcase
        end
        4'h8: begin rf_we = 1'b1; flags_d = alu_f; end
        4'h9: begin
          if (jmp_tkn) begin
            pc_d = rbv;
            case (ra)
              2'd0:    flags_d.z = 1'b0;
              2'd1:    flags_d.n = 1'b0;
              2'd2:    flags_d.c = 1'b0;
              default: flags_d.v = 1'b0;
            endcase
          end
        end
        4'hA: begin
          rf_we = 1'b1; rf_sel = ra; rf_wd = rav - 8'd1;
          if (rav != 8'd1) pc_d = rbv;
        end
        4'hB: begin
          case (ra)
            2'd0: pc_d = rbv;
            2'd1: begin
              mem_we = 1'b1; mem_wd = pc + 8'd1; sp_we = 1'b1; sp_wd = sp - 8'd1; pc_d = rbv;
            end
            2'd2: begin sp_we = 1'b1; sp_wd = sp + 8'd1; pc_d = dmem; end
            default: begin
              sp_we = 1'b1; sp_wd = sp + 8'd1; pc_d = dmem;
              flags_d = fsave_q; imask_d = 1'b0;
            end
          endcase
        end
        4'hC: if (ra != 2'd3) begin state_d = S_OP2; ir_d = instr; end
        4'hD: begin rf_we = 1'b1; rf_wd = dmem; end
        4'hE: begin mem_we = 1'b1; mem_wa = rav; end
        default: ;
      endcase
    end
    // Reset aborts whatever was in flight, including its memory write.
    if (!rstn) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_EXEC;
      ir_q    <= 8'h00;
      flags_q <= '0;
      fsave_q <= '0;
      imask_q <= 1'b0;
      oport_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      fsave_q <= fsave_d;
      imask_q <= imask_d;
      oport_q <= oport_d;
    end
  end

  assign O_Port = oport_q;
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Directed test of cpu_wrapper_v3: reset vector, nested CALL/RET, flags and
// conditional jumps, I/O, memory ops, reset abort and interrupt entry/RTI.

module tb_cpu_wrapper_v3;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] I_Port;
  logic       int_sig;
  logic [7:0] O_Port;
  int         total = 0;
  int         bad = 0;
  logic [7:0] idx;

  cpu_wrapper_v3 dut (
    .clk(clk), .rstn(rstn), .I_Port(I_Port), .int_sig(int_sig), .O_Port(O_Port)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] vec);
    dut.mem_inst.mem[0] = vec;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    dut.mem_inst.mem[a] = d;
  endtask

  initial begin
    rstn = 1'b0; I_Port = 8'h00; int_sig = 1'b0;
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;

    // nested CALL/RET program
    wr(8'h10, 8'hC0); wr(8'h11, 8'h20); wr(8'h12, 8'hB4); wr(8'h13, 8'h21);
    wr(8'h20, 8'hC1); wr(8'h21, 8'h01); wr(8'h22, 8'hC0); wr(8'h23, 8'h30);
    wr(8'h24, 8'h00); wr(8'h25, 8'hB4); wr(8'h26, 8'h00); wr(8'h27, 8'hB8);
    wr(8'h30, 8'hC2); wr(8'h31, 8'h02); wr(8'h32, 8'hB8);
    do_reset(8'h10);
    chk("rst_pc", dut.PC.pc_current, 8'h10);
    chk("rst_sp", dut.regfile_inst.regs[3], 8'hFF);
    chk("rst_oport", O_Port, 8'h00);
    tick(9);
    chk("call2_pc", dut.PC.pc_current, 8'h30);
    chk("call2_sp", dut.regfile_inst.regs[3], 8'hFD);
    chk("stk_ff", dut.mem_inst.mem[8'hFF], 8'h13);
    chk("stk_fe", dut.mem_inst.mem[8'hFE], 8'h26);
    tick(3); chk("ret2_pc", dut.PC.pc_current, 8'h26);
    tick(1); chk("nop_pc", dut.PC.pc_current, 8'h27);
    tick(1); chk("ret1_pc", dut.PC.pc_current, 8'h13);
    tick(1);
    chk("nest_r0", dut.regfile_inst.regs[0], 8'h31);
    chk("nest_r1", dut.regfile_inst.regs[1], 8'h01);
    chk("nest_r2", dut.regfile_inst.regs[2], 8'h02);
    chk("nest_sp", dut.regfile_inst.regs[3], 8'hFF);

    // ADD flags, JZ/JC taken then not taken after the flag is cleared
    wr(8'h60, 8'hC0); wr(8'h61, 8'hFF); wr(8'h62, 8'hC1); wr(8'h63, 8'h01);
    wr(8'h64, 8'hC2); wr(8'h65, 8'h40); wr(8'h66, 8'h21); wr(8'h67, 8'h92);
    wr(8'h40, 8'h92); wr(8'h41, 8'h9A);
    do_reset(8'h60);
    chk("rst2_r0", dut.regfile_inst.regs[0], 8'h00);
    chk("rst2_r1", dut.regfile_inst.regs[1], 8'h00);
    chk("rst2_r2", dut.regfile_inst.regs[2], 8'h00);
    chk("mem_kept", dut.mem_inst.mem[8'h12], 8'hB4);
    tick(6); chk("ldm_r0", dut.regfile_inst.regs[0], 8'hFF);
    tick(1); chk("add_r0", dut.regfile_inst.regs[0], 8'h00);
    tick(1); chk("jz_taken", dut.PC.pc_current, 8'h40);
    tick(1); chk("jz_cleared", dut.PC.pc_current, 8'h41);
    tick(1); chk("jc_taken", dut.PC.pc_current, 8'h40);
    tick(1); chk("jz_again", dut.PC.pc_current, 8'h41);
    tick(1); chk("jc_cleared", dut.PC.pc_current, 8'h42);

    // IN R1 / OUT R1
    wr(8'h70, 8'h7D); wr(8'h71, 8'h79);
    I_Port = 8'hA5;
    do_reset(8'h70);
    tick(1);
    chk("in_r1", dut.regfile_inst.regs[1], 8'hA5);
    chk("out_before", O_Port, 8'h00);
    tick(1); chk("out_after", O_Port, 8'hA5);

    // STD / LDD / PUSH / POP
    wr(8'hA0, 8'hC0); wr(8'hA1, 8'h5A); wr(8'hA2, 8'hC8); wr(8'hA3, 8'hC0);
    wr(8'hA4, 8'hC5); wr(8'hA5, 8'hC0); wr(8'hA6, 8'h70); wr(8'hA7, 8'h76);
    do_reset(8'hA0);
    chk("rst_oport2", O_Port, 8'h00);
    tick(4); chk("std_mem", dut.mem_inst.mem[8'hC0], 8'h5A);
    tick(2); chk("ldd_r1", dut.regfile_inst.regs[1], 8'h5A);
    tick(1);
    chk("push_sp", dut.regfile_inst.regs[3], 8'hFE);
    chk("push_mem", dut.mem_inst.mem[8'hFF], 8'h5A);
    tick(1);
    chk("pop_r2", dut.regfile_inst.regs[2], 8'h5A);
    chk("pop_sp", dut.regfile_inst.regs[3], 8'hFF);

    // reset landing on the second cycle of STD must suppress the write
    wr(8'hB0, 8'hC0); wr(8'hB1, 8'h77); wr(8'hB2, 8'hC8); wr(8'hB3, 8'hD0);
    wr(8'hD0, 8'h11);
    do_reset(8'hB0);
    tick(3);
    chk("pre_abort_r0", dut.regfile_inst.regs[0], 8'h77);
    rstn = 1'b0;
    tick(1);
    chk("abort_mem", dut.mem_inst.mem[8'hD0], 8'h11);
    chk("abort_pc", dut.PC.pc_current, 8'hB0);
    chk("abort_r0", dut.regfile_inst.regs[0], 8'h00);
    rstn = 1'b1;

    // interrupt at PC=15 with C set, handler clears C, RTI restores it
    wr(8'h10, 8'hC2); wr(8'h11, 8'h30); wr(8'h12, 8'h68); wr(8'h13, 8'h00);
    wr(8'h14, 8'h00); wr(8'h15, 8'h9A);
    wr(8'h01, 8'h50); wr(8'h50, 8'h6C); wr(8'h51, 8'hBC);
    do_reset(8'h10);
    tick(5); chk("pre_int_pc", dut.PC.pc_current, 8'h15);
    int_sig = 1'b1;
    tick(1);
    chk("int_pc", dut.PC.pc_current, 8'h50);
    chk("int_sp", dut.regfile_inst.regs[3], 8'hFE);
    idx = dut.regfile_inst.regs[3] + 8'd1;
    chk("int_stack", dut.mem_inst.mem[idx], 8'h15);
    tick(1); chk("int_masked", dut.PC.pc_current, 8'h51);
    int_sig = 1'b0;
    tick(1);
    chk("rti_pc", dut.PC.pc_current, 8'h15);
    chk("rti_sp", dut.regfile_inst.regs[3], 8'hFF);
    tick(1); chk("rti_flags", dut.PC.pc_current, 8'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
